// File: rtl/audio_pkg.sv
// Shared types for the equalizer audio path: fixed-point sample format, channel tag and
// receiver FSM states.
package audio_pkg;

    localparam int FRAC_BITS = 16;
    localparam int FIXED_W   = 32;

    typedef logic signed [FIXED_W-1:0] fixed_t;

    typedef enum logic {CH_LEFT, CH_RIGHT} channel_t;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_DONE} state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchroniser for one asynchronous codec line, with a history flop for
// rise and any-edge detection in the i_clk domain.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   primed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_in};
            hist_q  <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are masked until the history flop holds a real sampled level, so the
    // cleared-after-reset state never looks like a transition.
    assign primed  = prime_q[SYNC_STAGES];
    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = primed & o_level & ~hist_q;
    assign o_edge  = primed & (o_level ^ hist_q);

endmodule

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: oversamples BCLK/LRC/ADCDAT, deserialises one word per channel and
// emits it as 16.16 fixed point with a one-cycle valid strobe and channel tag.
module audio_adc_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int FRAC_BITS   = audio_pkg::FRAC_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_DELAY   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_bclk,
    input  logic        i_lrc,
    input  logic        i_adcdat,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_right,
    output logic        o_err
);
    import audio_pkg::*;

    localparam int CNT_W  = $clog2(SAMPLE_BITS + 1);
    localparam int SKIP_W = (BIT_DELAY > 0) ? $clog2(BIT_DELAY + 1) : 1;
    localparam int FULL_W = SAMPLE_BITS + FRAC_BITS;

    logic bclk_level, bclk_rise, bclk_edge;
    logic lrc_level, lrc_rise, lrc_edge;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic dat;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_bclk),
        .o_level(bclk_level),
        .o_rise (bclk_rise),
        .o_edge (bclk_edge)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrc_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_lrc),
        .o_level(lrc_level),
        .o_rise (lrc_rise),
        .o_edge (lrc_edge)
    );

    // Same depth as the clock syncs so data lines up with the detected BCLK rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) dat_sync_q <= '0;
        else       dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_adcdat};
    end
    assign dat = dat_sync_q[SYNC_STAGES-1];

    logic unused_sync;
    assign unused_sync = ^{bclk_level, bclk_edge, lrc_rise};

    state_t                 state_q, state_d;
    channel_t               ch_q, ch_d;
    logic [SKIP_W-1:0]      skip_q, skip_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic                   start, err;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        start   = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: start = lrc_edge;
            S_SKIP: begin
                if (lrc_edge) begin
                    err   = 1'b1;
                    start = 1'b1;
                end else if (bclk_rise) begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == SKIP_W'(1)) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                    end
                end
            end
            S_SHIFT: begin
                if (lrc_edge) begin
                    err   = 1'b1;
                    start = 1'b1;
                end else if (bclk_rise) begin
                    shift_d = {shift_q[SAMPLE_BITS-2:0], dat};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SAMPLE_BITS - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                start   = lrc_edge;
            end
            default: state_d = S_IDLE;
        endcase

        // A coincident BCLK rise is consumed by the new frame as its first edge.
        if (start) begin
            ch_d  = channel_t'(lrc_level);
            cnt_d = '0;
            if (BIT_DELAY == 0) begin
                state_d = S_SHIFT;
                if (bclk_rise) begin
                    shift_d = {shift_q[SAMPLE_BITS-2:0], dat};
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                state_d = S_SKIP;
                skip_d  = SKIP_W'(BIT_DELAY);
                if (bclk_rise) begin
                    skip_d = SKIP_W'(BIT_DELAY - 1);
                    if (BIT_DELAY == 1) state_d = S_SHIFT;
                end
            end
        end

        if (!i_en) begin
            state_d = S_IDLE;
            err     = 1'b0;
        end
    end

    logic [FULL_W-1:0] full;
    fixed_t            fixed;
    assign full = {shift_q, {FRAC_BITS{1'b0}}};

    if (FULL_W >= FIXED_W) begin : g_trunc
        assign fixed = full[FIXED_W-1:0];
    end else begin : g_sext
        assign fixed = {{(FIXED_W - FULL_W){shift_q[SAMPLE_BITS-1]}}, full};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ch_q    <= CH_LEFT;
            skip_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_right <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            o_valid <= i_en && (state_q == S_DONE);
            o_err   <= err;
            if (i_en && (state_q == S_DONE)) begin
                o_data  <= fixed;
                o_right <= (ch_q == CH_RIGHT);
            end
        end
    end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Upstream stage of the equalizer filter bank. Receives the codec's I2S ADC stream (BCLK, ADCLRC, ADCDAT) and deserialises one signed 16-bit sample per channel.
- Converts each sample to the 32-bit 16.16 fixed-point format that the biquad stages take on i_data.
- Emits each sample with a one-cycle valid strobe and a channel tag.
- Runs in the system clock domain and oversamples the codec serial clock.

Parameters:
- SAMPLE_BITS, 16, bits per channel word captured from ADCDAT, MSB first.
- FRAC_BITS, 16, fractional bits of the output fixed-point word.
- SYNC_STAGES, 2, flip-flop stages on each codec input (minimum 2).
- BIT_DELAY, 1, BCLK rising edges skipped after an LRC edge before the MSB (1 = I2S, 0 = left-justified).

Ports:
- i_clk  input  1  system clock; at least 4x BCLK.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  receiver enable; low returns the block to idle.
- i_bclk  input  1  codec bit clock, asynchronous to i_clk.
- i_lrc  input  1  codec ADC LR clock; 0 = left, 1 = right.
- i_adcdat  input  1  codec serial ADC data.
- o_data  output  32  sample in 16.16 fixed point: sample in [31:16], zeros in [15:0].
- o_valid  output  1  one-cycle strobe; o_data and o_right are valid in this cycle.
- o_right  output  1  channel of the current o_data (0 left, 1 right).
- o_err  output  1  one-cycle pulse: a frame was truncated by an early LRC edge.

Behaviour:
- Reset (i_rst high at a rising edge of i_clk):
  - o_data = 0, o_valid = 0, o_right = 0, o_err = 0.
  - FSM goes to S_IDLE. Synchroniser and edge-history registers are cleared.
- Synchronisation:
  - i_bclk, i_lrc and i_adcdat each pass through SYNC_STAGES flops of identical depth, so the three stay aligned.
  - The edge detector compares the last sync stage with one history flop.
  - bclk_rise = last stage 1, history 0. lrc_edge = last stage differs from history.
- FSM states:
  - S_IDLE: waits for lrc_edge while i_en is 1. Latches ch = new LRC level and loads skip = BIT_DELAY. Goes to S_SKIP if BIT_DELAY > 0, else to S_SHIFT.
  - S_SKIP: each bclk_rise decrements skip. When skip reaches 0, goes to S_SHIFT with bit counter = 0.
  - S_SHIFT: each bclk_rise shifts the synchronised ADCDAT into the shift register's LSB end and increments the counter. When the counter reaches SAMPLE_BITS, goes to S_DONE.
  - S_DONE: held for exactly one cycle, then goes to S_IDLE.
- Output on S_DONE:
  - In the cycle after S_DONE: o_valid = 1, o_right = ch, o_data = {shift[15:0], FRAC_BITS zeros}.
  - The sample's sign is carried by bit 31, so no extension is needed for the 16/16 defaults. For other parameter values, the result is sign-extended or truncated to 32 bits from the MSB.
- Latency: o_valid rises SYNC_STAGES + 2 i_clk cycles after the BCLK rising edge that carries the LSB.
- o_data and o_right hold their value between strobes. o_valid is never high for two consecutive cycles.
- Extra BCLK bits after SAMPLE_BITS, before the next LRC edge, are ignored. In S_IDLE only lrc_edge is acted on.
- Early LRC edge (in S_SKIP or S_SHIFT before SAMPLE_BITS bits are captured):
  - The partial word is discarded and o_err pulses for one cycle.
  - The FSM restarts capture for the new channel as if from S_IDLE, in the same cycle; no frame is lost.
- lrc_edge coinciding with S_DONE: the sample is still emitted, and the new frame starts on the following cycle. The capture is kept because the LRC edge precedes the next BCLK rise by half a BCLK period.
- i_en low: the FSM is forced to S_IDLE on the next edge. No o_valid or o_err is produced, and o_data keeps its last value.
- After i_en rises again, or after reset is released mid-frame, no sample is emitted until a full LRC edge has been seen. Partial frames are never output.
- Simultaneous bclk_rise and lrc_edge in S_IDLE: the edge is taken, and that bclk_rise counts as the first skip edge (or the MSB if BIT_DELAY = 0).

Decomposition:
- Shared package audio_pkg, holding:
  - FRAC_BITS = 16 and the fixed-point width 32.
  - typedef fixed_t (logic signed [31:0]).
  - enum channel_t {CH_LEFT, CH_RIGHT}.
  - The FSM state enum {S_IDLE, S_SKIP, S_SHIFT, S_DONE}.
- Sub-module edge_sync: SYNC_STAGES synchroniser plus history flop; outputs the level, the rise and the any-edge signal. It is instantiated for bclk and lrc. adcdat uses the same sync depth without edge outputs.

Test Plan:
- Left 0x1234, then right 0xFEDC, in I2S frames (BIT_DELAY = 1, BCLK = i_clk/8) -> o_valid twice; o_data = 0x12340000 with o_right = 0, then 0xFEDC0000 with o_right = 1; strobe SYNC_STAGES + 2 cycles after each LSB edge.
- Left word 0x8000 -> o_data = 0x80000000 (most negative); word 0x7FFF -> 0x7FFF0000.
- LRC toggles after 9 bits of a left frame -> o_err = 1 for one cycle, no o_valid for that frame; the following full right frame 0x00FF -> o_data = 0x00FF0000, o_right = 1.
- 20 BCLK edges per channel (4 extra bits of 1s) with word 0x0F0F -> o_data = 0x0F0F0000; the extra bits have no effect.
- i_rst pulsed at bit 7 of a frame -> all outputs 0 immediately; the partial frame is not emitted; the first o_valid comes from the next complete frame.
- i_en low for 3 frames -> no o_valid and o_data unchanged; i_en raised mid-frame -> the partial frame is dropped and capture resumes at the next LRC edge.
